// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: state encoding, opcodes, PC/ARITH select codes, control vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cu_pkg;

   // FSM state encoding (3-bit register); STEPWAIT exists only in the single-step build
   typedef enum logic [2:0] {
      ST_FETCH    = 3'd0,
      ST_DECODE   = 3'd1,
      ST_EXEC     = 3'd2,
      ST_INWAIT   = 3'd3,
`ifdef CU_SINGLE_STEP_EN
      ST_STEPWAIT = 3'd5,
`endif
      ST_HALT     = 3'd4
   } state_t;

   // Opcodes (IR158[8:3])
   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_LDA  = 6'h01;
   localparam logic [5:0] OP_STA  = 6'h02;
   localparam logic [5:0] OP_LDR  = 6'h03;
   localparam logic [5:0] OP_STR  = 6'h04;
   localparam logic [5:0] OP_LDI  = 6'h05;
   localparam logic [5:0] OP_ADD  = 6'h06;
   localparam logic [5:0] OP_SUB  = 6'h07;
   localparam logic [5:0] OP_IN   = 6'h08;
   localparam logic [5:0] OP_OUT  = 6'h09;
   localparam logic [5:0] OP_JMP  = 6'h0A;
   localparam logic [5:0] OP_JZ   = 6'h0B;
   localparam logic [5:0] OP_JP   = 6'h0C;
   localparam logic [5:0] OP_JR   = 6'h0D;
   localparam logic [5:0] OP_HALT = 6'h3F;

   // PC source selects
   localparam logic [1:0] JSEL_PC1 = 2'b00;
   localparam logic [1:0] JSEL_REL = 2'b01;
   localparam logic [1:0] JSEL_ABS = 2'b10;

   // ARITH source selects
   localparam logic [2:0] ASEL_PASS = 3'd0;
   localparam logic [2:0] ASEL_REG  = 3'd1;
   localparam logic [2:0] ASEL_MEM  = 3'd2;
   localparam logic [2:0] ASEL_IMM  = 3'd3;
   localparam logic [2:0] ASEL_IN   = 3'd4;
   localparam logic [2:0] ASEL_ADD  = 3'd5;
   localparam logic [2:0] ASEL_SUB  = 3'd6;

   // Jump condition attached to a decoded instruction
   localparam logic [1:0] JC_NONE   = 2'd0;
   localparam logic [1:0] JC_ALWAYS = 2'd1;
   localparam logic [1:0] JC_ZERO   = 2'd2;
   localparam logic [1:0] JC_POS    = 2'd3;

   // Decoded control vector: EXEC-cycle strobes plus sequencing hints
   typedef struct packed {
      logic       pcload;
      logic       jmpmux;
      logic       meminst;
      logic       memwr;
      logic       regwr;
      logic       aload;
      logic       sub;
      logic       out;
      logic       sel01;
      logic [1:0] jsel;
      logic [2:0] asel0;
      logic [2:0] asel1;
      logic [1:0] jcond;
      logic       is_in;
      logic       is_halt;
      logic       illegal;
   } ctl_t;

   // Resolve whether a jump is taken from its condition and the accumulator flags
   function automatic logic jump_taken(input logic [1:0] jcond, input logic aeq0, input logic apos);
      logic taken;
      taken = 1'b0;
      case (jcond)
         JC_ALWAYS: taken = 1'b1;
         JC_ZERO:   taken = aeq0;
         JC_POS:    taken = apos;
         default:   taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: maps IR158 to the EXEC-cycle control vector; undefined opcodes decode as NOP + illegal.
// Latency: purely combinational.
// Backpressure: none.
module cu_decode
   import cu_pkg::*;
(
   input  logic [8:0] IR158,
   output ctl_t       ctl
);

   logic [5:0] opcode;
   logic [2:0] unused_regidx;

   assign opcode        = IR158[8:3];
   // Register index feeds the datapath directly; the controller does not need it
   assign unused_regidx = IR158[2:0];

   // Opcode table
   always_comb begin
      ctl = '0;
      case (opcode)
         OP_NOP: ;
         OP_LDA: begin
            ctl.meminst = 1'b1;
            ctl.sel01   = 1'b1;
            ctl.asel1   = ASEL_MEM;
            ctl.aload   = 1'b1;
         end
         OP_STA: begin
            ctl.meminst = 1'b1;
            ctl.memwr   = 1'b1;
         end
         OP_LDR: begin
            ctl.sel01 = 1'b1;
            ctl.asel1 = ASEL_REG;
            ctl.aload = 1'b1;
         end
         OP_STR: ctl.regwr = 1'b1;
         OP_LDI: begin
            ctl.sel01 = 1'b1;
            ctl.asel1 = ASEL_IMM;
            ctl.aload = 1'b1;
         end
         OP_ADD: begin
            ctl.asel0 = ASEL_ADD;
            ctl.aload = 1'b1;
         end
         OP_SUB: begin
            ctl.asel0 = ASEL_SUB;
            ctl.sub   = 1'b1;
            ctl.aload = 1'b1;
         end
         OP_IN:  ctl.is_in = 1'b1;
         OP_OUT: ctl.out   = 1'b1;
         OP_JMP, OP_JZ, OP_JP: begin
            ctl.jsel   = JSEL_ABS;
            ctl.jmpmux = 1'b1;
            ctl.pcload = 1'b1;
            ctl.jcond  = (opcode == OP_JZ) ? JC_ZERO :
                         (opcode == OP_JP) ? JC_POS  : JC_ALWAYS;
         end
         OP_JR: begin
            ctl.jsel   = JSEL_REL;
            ctl.jmpmux = 1'b1;
            ctl.pcload = 1'b1;
            ctl.jcond  = JC_ALWAYS;
         end
         OP_HALT: ctl.is_halt = 1'b1;
         default: ctl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle CPU controller FSM (FETCH/DECODE/EXEC/INWAIT/HALT); CU_SINGLE_STEP_EN adds Step and STEPWAIT.
// Latency: 3 cycles per non-I/O instruction; outputs are combinational from state and IR158.
// Backpressure: IN stalls in INWAIT until Enter; single-step build stalls in STEPWAIT until Step.
module control_unit
   import cu_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset,
   input  logic [8:0] IR158,
   input  logic       Aeq0,
   input  logic       Apos,
   input  logic       Enter,
`ifdef CU_SINGLE_STEP_EN
   input  logic       Step,
`endif
   output logic       IRload,
   output logic       PCload,
   output logic       JMPmux,
   output logic       Meminst,
   output logic       MemWr,
   output logic       RegWr,
   output logic       Aload,
   output logic       Sub,
   output logic       out,
   output logic       sel01,
   output logic [1:0] Jsel,
   output logic [2:0] Asel0,
   output logic [2:0] Asel1,
   output logic       Halted,
   output logic       IllegalOp
);

   state_t state_q;
   state_t state_d;
   ctl_t   ctl;
   logic   taken;

`ifdef CU_SINGLE_STEP_EN
   localparam state_t NEXT_INSTR = ST_STEPWAIT;
`else
   localparam state_t NEXT_INSTR = ST_FETCH;
`endif

   cu_decode u_decode (
      .IR158 (IR158),
      .ctl   (ctl)
   );

   assign taken = jump_taken(ctl.jcond, Aeq0, Apos);

   // State register; reset returns to FETCH without waiting for a clock
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= ST_FETCH;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: begin
            if (ctl.is_in)        state_d = ST_INWAIT;
            else if (ctl.is_halt) state_d = ST_HALT;
            else                  state_d = ST_EXEC;
         end
         ST_EXEC:   state_d = NEXT_INSTR;
         ST_INWAIT: if (Enter) state_d = NEXT_INSTR;
         ST_HALT:   state_d = ST_HALT;
`ifdef CU_SINGLE_STEP_EN
         ST_STEPWAIT: if (Step) state_d = ST_FETCH;
`endif
         default:   state_d = ST_FETCH;
      endcase
   end

   // Output decode; everything is forced low while Reset is asserted
   always_comb begin
      IRload    = 1'b0;
      PCload    = 1'b0;
      JMPmux    = 1'b0;
      Meminst   = 1'b0;
      MemWr     = 1'b0;
      RegWr     = 1'b0;
      Aload     = 1'b0;
      Sub       = 1'b0;
      out       = 1'b0;
      sel01     = 1'b0;
      Jsel      = JSEL_PC1;
      Asel0     = ASEL_PASS;
      Asel1     = ASEL_PASS;
      Halted    = 1'b0;
      IllegalOp = 1'b0;
      if (!Reset) begin
         case (state_q)
            ST_FETCH: begin
               IRload  = 1'b1;
               PCload  = 1'b1;
               Meminst = 1'b0;
               Jsel    = JSEL_PC1;
            end
            ST_DECODE: IllegalOp = ctl.illegal;
            ST_EXEC: begin
               Meminst = ctl.meminst;
               MemWr   = ctl.memwr;
               RegWr   = ctl.regwr;
               Aload   = ctl.aload;
               Sub     = ctl.sub;
               out     = ctl.out;
               sel01   = ctl.sel01;
               Asel0   = ctl.asel0;
               Asel1   = ctl.asel1;
               // An untaken jump leaves PC at fetched+1, so drop the whole jump path
               if (ctl.jcond != JC_NONE && taken) begin
                  PCload = ctl.pcload;
                  JMPmux = ctl.jmpmux;
                  Jsel   = ctl.jsel;
               end
            end
            ST_INWAIT: begin
               if (Enter) begin
                  sel01 = 1'b1;
                  Asel1 = ASEL_IN;
                  Aload = 1'b1;
               end
            end
            ST_HALT: Halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
